// File: rtl/button_pkg.sv
// Shared defaults and helpers for the push-button conditioning block.
package button_pkg;

    localparam int unsigned BTN_WIDTH_DEFAULT       = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Ceiling log2, used to size the stability counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, polarity normalization,
// stability counter and registered press/release strobes.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic             RAW_IDLE = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    logic             w_norm;
    logic             w_differ;
    logic             w_accept;

    always_comb begin
        w_norm   = ACTIVE_LOW ? ~r_sync2 : r_sync2;
        w_differ = w_norm ^ r_state;
        w_accept = w_differ && (r_cnt == CNT_MAX);
    end

    // Synchronizers idle at the released pin level so reset release is silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= RAW_IDLE;
            r_sync2   <= RAW_IDLE;
            r_state   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_press   <= w_accept & w_norm;
            r_release <= w_accept & ~w_norm;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_state <= w_norm;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign debounced     = r_state;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer feeding the button PIO in_port,
// plus one-cycle press/release strobes per channel.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned WIDTH           = BTN_WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_buttons,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw           (raw_buttons[g]),
            .debounced     (debounced[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (WIDTH=4, DEBOUNCE_CYCLES=8, active-low pins).
module tb_button_debouncer;

    localparam int unsigned W   = 4;
    localparam int unsigned D   = 8;
    localparam int          LAT = D + 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] raw_buttons;
    logic [W-1:0] debounced;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    typedef struct {
        int           cyc;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    button_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_buttons   (raw_buttons),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe seen must match the next expected event, cycle-exact.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (press_pulse | release_pulse) !== '0) begin
            checks++;
            if ((press_pulse & release_pulse) !== '0) begin
                errors++;
                $display("FAIL strobe_overlap cyc=%0d press=%b release=%b", cyc, press_pulse, release_pulse);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b required none", cyc, press_pulse, release_pulse);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.cyc || press_pulse !== mon_e.press || release_pulse !== mon_e.rel) begin
                    errors++;
                    $display("FAIL strobe_event got cyc=%0d press=%b release=%b required cyc=%0d press=%b release=%b",
                             cyc, press_pulse, release_pulse, mon_e.cyc, mon_e.press, mon_e.rel);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        raw_buttons = '1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (debounced !== '0 || press_pulse !== '0 || release_pulse !== '0) begin
            errors++;
            $display("FAIL reset_outputs got deb=%b press=%b rel=%b required 0", debounced, press_pulse, release_pulse);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(100);
        checks++;
        if (debounced !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle got deb=%b required 0000", debounced);
        end
    endtask

    task automatic test_clean_press();
        raw_buttons[0] = 1'b0;
        sb.push_back('{cyc + LAT, 4'b0001, 4'b0000});
        wait_cycles(LAT - 1);
        checks++;
        if (debounced !== 4'b0000) begin
            errors++;
            $display("FAIL press_early got deb=%b required 0000", debounced);
        end
        wait_cycles(1);
        checks++;
        if (debounced !== 4'b0001 || press_pulse !== 4'b0001) begin
            errors++;
            $display("FAIL press_accept got deb=%b press=%b required 0001/0001", debounced, press_pulse);
        end
        wait_cycles(1);
        checks++;
        if (press_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL press_one_cycle got press=%b required 0000", press_pulse);
        end
        wait_cycles(20);
        checks++;
        if (debounced !== 4'b0001) begin
            errors++;
            $display("FAIL press_hold got deb=%b required 0001", debounced);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 13; i++) begin
            raw_buttons[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i == 12) sb.push_back('{cyc + LAT, 4'b0010, 4'b0000});
            wait_cycles(3);
            if (i == 6) begin
                checks++;
                if (debounced !== 4'b0001) begin
                    errors++;
                    $display("FAIL bounce_mid got deb=%b required 0001", debounced);
                end
            end
        end
        wait_cycles(LAT - 4);
        checks++;
        if (debounced !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_early got deb=%b required 0001", debounced);
        end
        wait_cycles(1);
        checks++;
        if (debounced !== 4'b0011) begin
            errors++;
            $display("FAIL bounce_accept got deb=%b required 0011", debounced);
        end
    endtask

    task automatic test_glitch();
        raw_buttons[2] = 1'b0;
        wait_cycles(D - 1);
        raw_buttons[2] = 1'b1;
        wait_cycles(20);
        checks++;
        if (debounced !== 4'b0011) begin
            errors++;
            $display("FAIL glitch_reject got deb=%b required 0011", debounced);
        end
    endtask

    task automatic test_simultaneous();
        raw_buttons[3] = 1'b0;
        sb.push_back('{cyc + LAT, 4'b1000, 4'b0000});
        wait_cycles(LAT + 2);
        checks++;
        if (debounced !== 4'b1011) begin
            errors++;
            $display("FAIL simul_setup got deb=%b required 1011", debounced);
        end
        raw_buttons[3] = 1'b1;
        raw_buttons[2] = 1'b0;
        sb.push_back('{cyc + LAT, 4'b0100, 4'b1000});
        wait_cycles(LAT);
        checks++;
        if (debounced !== 4'b0111 || press_pulse !== 4'b0100 || release_pulse !== 4'b1000) begin
            errors++;
            $display("FAIL simul_accept got deb=%b press=%b rel=%b required 0111/0100/1000",
                     debounced, press_pulse, release_pulse);
        end
        wait_cycles(1);
        checks++;
        if (press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL simul_clear got press=%b rel=%b required 0000/0000", press_pulse, release_pulse);
        end
    endtask

    task automatic test_reset_mid();
        raw_buttons[3] = 1'b0;
        wait_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_before_reset got %0d required 0", sb.size());
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (debounced !== '0 || press_pulse !== '0 || release_pulse !== '0) begin
            errors++;
            $display("FAIL reset_async got deb=%b press=%b rel=%b required 0", debounced, press_pulse, release_pulse);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        sb.push_back('{cyc + LAT, 4'b1111, 4'b0000});
        wait_cycles(LAT - 1);
        checks++;
        if (debounced !== 4'b0000) begin
            errors++;
            $display("FAIL reset_reaccept_early got deb=%b required 0000", debounced);
        end
        wait_cycles(1);
        checks++;
        if (debounced !== 4'b1111) begin
            errors++;
            $display("FAIL reset_reaccept got deb=%b required 1111", debounced);
        end
    endtask

    task automatic test_release_all();
        raw_buttons = '1;
        sb.push_back('{cyc + LAT, 4'b0000, 4'b1111});
        wait_cycles(LAT + 1);
        checks++;
        if (debounced !== 4'b0000) begin
            errors++;
            $display("FAIL release_all got deb=%b required 0000", debounced);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_release_all();
        wait_cycles(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions raw push-button inputs before they reach the button PIO's `in_port`.
- Per channel it synchronizes the pin, normalizes polarity to active-high "pressed", and filters contact bounce with a stability counter.
- It also emits one-cycle press/release strobes for logic that does not go through the PIO edge capture.
- A rising edge on `debounced` means exactly one press, so the PIO edge-capture register latches once per physical press.

Parameters:
- WIDTH, 4: number of button channels.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new level. Default is 1 ms at 50 MHz. Legal range ≥2.
- ACTIVE_LOW, 1: 1 means the raw pin reads 0 when pressed. 0 means the raw pin reads 1 when pressed.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width. Derived; do not override.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- raw_buttons  in  WIDTH  asynchronous board pins.
- debounced  out  WIDTH  filtered level, 1 = pressed. Feeds PIO `in_port`.
- press_pulse  out  WIDTH  one-cycle strobe on each accepted press.
- release_pulse  out  WIDTH  one-cycle strobe on each accepted release.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - reset_n is asynchronous and active-low; every flop clears on its falling edge.
- Reset values:
  - Synchronizer flops reset to the raw inactive level (ACTIVE_LOW ? 1 : 0), so releasing reset with no button held creates no event.
  - debounced = 0, press_pulse = 0, release_pulse = 0, all counters = 0.
- Synchronizer:
  - Two flops per bit: sync1 <= raw, sync2 <= sync1.
  - Polarity normalization: norm = ACTIVE_LOW ? ~sync2 : sync2.
  - Only norm is used downstream; raw_buttons never reaches other logic directly.
- Per-channel filter (channels fully independent). Each rising edge:
  - norm == state: cnt <= 0. No event.
  - norm != state and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - norm != state and cnt == DEBOUNCE_CYCLES-1: state <= norm, cnt <= 0, and the matching strobe asserts for exactly this cycle (press_pulse if norm = 1, release_pulse if norm = 0).
- Output timing:
  - debounced = state, registered.
  - press_pulse is high in the same cycle debounced first reads 1; release_pulse likewise when debounced first reads 0.
  - Strobes are registered and self-clear after one cycle.
- Latency: a clean raw transition appears on debounced exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value (2 synchronizer edges + DEBOUNCE_CYCLES filter edges).
- Glitch rejection:
  - Any disagreement run shorter than DEBOUNCE_CYCLES resets cnt to 0 on the first agreeing cycle.
  - Bounce therefore restarts the count and produces no output change.
- Boundary conditions:
  - Counter never wraps. It is bounded at DEBOUNCE_CYCLES-1 and cleared on acceptance.
  - Simultaneous transitions on several channels are each accepted independently; several strobe bits may be high in the same cycle.
  - press_pulse and release_pulse are never both high on the same bit.
  - Button held indefinitely: debounced stays 1; no further strobes.
  - Reset asserted mid-count or mid-press: all state is lost; outputs read 0 immediately (asynchronously).
  - After reset release with the button still held: a press is re-accepted DEBOUNCE_CYCLES+2 edges later, with a fresh press_pulse.

Decomposition:
- Shared package (button_pkg):
  - BTN_WIDTH_DEFAULT = 4
  - DEBOUNCE_CYCLES_DEFAULT = 50000
  - Function clog2 for the CNT_W derivation.
- Sub-module debounce_channel:
  - Holds one bit's synchronizer, counter, state and strobe logic.
  - The top module instantiates WIDTH copies with a generate loop and concatenates the outputs.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1; raw idles at 4'b1111):
- Reset release, raw idle: 100 cycles after reset_n rises → debounced = 4'b0000; no strobe ever asserts.
- Clean press: raw[0] driven 0 and held → debounced[0] rises exactly 10 edges later; press_pulse = 4'b0001 for one cycle only.
- Bounce: raw[1] toggles 0/1 every 3 cycles for 40 cycles, then held 0 → no change until 10 edges after the final toggle; exactly one press_pulse[1].
- Glitch: raw[2] low for 7 cycles, then back high → debounced[2] stays 0; no strobes on bit 2.
- Simultaneous press and release: with debounced[3] = 1, release raw[3] and press raw[2] on the same edge → 10 edges later press_pulse = 4'b0100 and release_pulse = 4'b1000 in the same cycle.
- Reset mid-operation: assert reset_n while debounced[0] = 1 and raw[0] is still held → outputs read 0 immediately. After release, debounced[0] returns to 1 after 10 edges with one press_pulse[0].
